// File: rtl/pc_stack.sv
// Program counter with load/increment plus call/return through a LIFO return-address stack.
// addr and all status are registered (one-cycle latency); no handshake, every command acts in its cycle.
module pc_stack #(
  parameter int ADDR_W     = 12,
  parameter int DEPTH      = 4,
  parameter int RESET_ADDR = 0,
  parameter int INC_STEP   = 1
) (
  input  logic                         clk,
  input  logic                         Rst,
  input  logic [ADDR_W-1:0]            newaddr,
  input  logic                         loadPC,
  input  logic                         incPC,
  input  logic                         call,
  input  logic                         ret,
  output logic [ADDR_W-1:0]            addr,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [ADDR_W-1:0] stack_q [DEPTH];

  logic              push_en;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic [ADDR_W-1:0] addr_inc;
  logic              full;
  logic              empty;

  assign addr_inc = addr_q + ADDR_W'(INC_STEP);
  assign full     = (sp_q == SP_W'(DEPTH));
  assign empty    = (sp_q == '0);
  // Truncation is safe: sp is only used as an index when it is in range.
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    addr_d      = addr_q;
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_en     = 1'b0;

    if (ret) begin
      if (!empty) begin
        addr_d = stack_q[pop_idx];
        sp_d   = sp_q - SP_W'(1);
      end else begin
        underflow_d = 1'b1;
      end
    end else if (call) begin
      // A call on a full stack is dropped entirely, including the jump.
      if (!full) begin
        push_en = 1'b1;
        sp_d    = sp_q + SP_W'(1);
        addr_d  = newaddr;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (loadPC) begin
      addr_d = newaddr;
    end else if (incPC) begin
      addr_d = addr_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      addr_q      <= ADDR_W'(RESET_ADDR);
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Return-address storage is never cleared; entries above sp are don't-care.
  always_ff @(posedge clk) begin
    if (push_en && !Rst) begin
      stack_q[push_idx] <= addr_inc;
    end
  end

  assign addr        = addr_q;
  assign sp          = sp_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed scoreboard bench for pc_stack: stimulus queues expected state, a monitor checks it after each edge.
module tb_pc_stack;

  typedef struct packed {
    logic [11:0] addr;
    logic [2:0]  sp;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
  } st_t;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic [11:0] newaddr = '0;
  logic        loadPC = 1'b0;
  logic        incPC = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [11:0] addr;
  logic [2:0]  sp;
  logic        stack_full;
  logic        stack_empty;
  logic        overflow;
  logic        underflow;

  st_t   exp_q  [$];
  string name_q [$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    done  = 1'b0;

  always #5 clk = ~clk;

  pc_stack #(
    .ADDR_W(12), .DEPTH(4), .RESET_ADDR(0), .INC_STEP(1)
  ) dut (
    .clk(clk), .Rst(Rst), .newaddr(newaddr), .loadPC(loadPC), .incPC(incPC),
    .call(call), .ret(ret), .addr(addr), .sp(sp), .stack_full(stack_full),
    .stack_empty(stack_empty), .overflow(overflow), .underflow(underflow)
  );

  // Monitor: every cycle with a pending expectation, compare the registered state.
  initial begin
    st_t e;
    st_t a;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{addr, sp, stack_full, stack_empty, overflow, underflow};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s: got addr=%h sp=%0d full=%b empty=%b ovf=%b unf=%b, want addr=%h sp=%0d full=%b empty=%b ovf=%b unf=%b",
                   nm, a.addr, a.sp, a.full, a.empty, a.ovf, a.unf,
                   e.addr, e.sp, e.full, e.empty, e.ovf, e.unf);
        end
      end
    end
  end

  // cmd bits: {rst, ret, call, load, inc}
  task automatic step(input logic [4:0] cmd, input logic [11:0] na,
                      input logic [11:0] e_addr, input logic [2:0] e_sp,
                      input logic e_ovf, input logic e_unf, input string nm);
    st_t e;
    {Rst, ret, call, loadPC, incPC} = cmd;
    newaddr = na;
    e = '{e_addr, e_sp, (e_sp == 3'd4), (e_sp == 3'd0), e_ovf, e_unf};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  localparam logic [4:0] C_RST  = 5'b10000;
  localparam logic [4:0] C_RET  = 5'b01000;
  localparam logic [4:0] C_CALL = 5'b00100;
  localparam logic [4:0] C_LOAD = 5'b00010;
  localparam logic [4:0] C_INC  = 5'b00001;
  localparam logic [4:0] C_NONE = 5'b00000;

  initial begin
    // 1. reset and increment
    step(C_RST, 12'h000, 12'h000, 3'd0, 1'b0, 1'b0, "reset");
    for (int i = 1; i <= 5; i++)
      step(C_INC, 12'h000, 12'(i), 3'd0, 1'b0, 1'b0, "inc_run");

    // 2. wrap and reset priority over increment
    step(C_LOAD, 12'hFFE, 12'hFFE, 3'd0, 1'b0, 1'b0, "load_ffe");
    step(C_INC,  12'h000, 12'hFFF, 3'd0, 1'b0, 1'b0, "inc_fff");
    step(C_INC,  12'h000, 12'h000, 3'd0, 1'b0, 1'b0, "inc_wrap");
    step(C_INC,  12'h000, 12'h001, 3'd0, 1'b0, 1'b0, "inc_001");
    step(C_RST | C_INC, 12'h000, 12'h000, 3'd0, 1'b0, 1'b0, "rst_over_inc");

    // 3. call/return pair
    step(C_LOAD, 12'h010, 12'h010, 3'd0, 1'b0, 1'b0, "load_010");
    step(C_CALL, 12'h200, 12'h200, 3'd1, 1'b0, 1'b0, "call_200");
    step(C_INC,  12'h000, 12'h201, 3'd1, 1'b0, 1'b0, "sub_inc1");
    step(C_INC,  12'h000, 12'h202, 3'd1, 1'b0, 1'b0, "sub_inc2");
    step(C_RET,  12'h000, 12'h011, 3'd0, 1'b0, 1'b0, "ret_011");
    step(C_NONE, 12'h5A5, 12'h011, 3'd0, 1'b0, 1'b0, "hold");

    // 4. nested calls to full, overflow, unwind
    step(C_RST,  12'h000, 12'h000, 3'd0, 1'b0, 1'b0, "reset2");
    step(C_CALL, 12'h100, 12'h100, 3'd1, 1'b0, 1'b0, "call1");
    step(C_CALL, 12'h200, 12'h200, 3'd2, 1'b0, 1'b0, "call2");
    step(C_CALL, 12'h300, 12'h300, 3'd3, 1'b0, 1'b0, "call3");
    step(C_CALL, 12'h400, 12'h400, 3'd4, 1'b0, 1'b0, "call4_full");
    step(C_CALL, 12'h500, 12'h400, 3'd4, 1'b1, 1'b0, "call5_ovf");
    step(C_RET,  12'h000, 12'h301, 3'd3, 1'b1, 1'b0, "ret4");
    step(C_RET,  12'h000, 12'h201, 3'd2, 1'b1, 1'b0, "ret3");
    step(C_RET,  12'h000, 12'h101, 3'd1, 1'b1, 1'b0, "ret2");
    step(C_RET,  12'h000, 12'h001, 3'd0, 1'b1, 1'b0, "ret1");

    // 5. underflow and command priority (overflow stays sticky)
    step(C_LOAD, 12'h033, 12'h033, 3'd0, 1'b1, 1'b0, "load_033");
    step(C_RET,  12'h000, 12'h033, 3'd0, 1'b1, 1'b1, "ret_unf");
    step(C_CALL | C_LOAD | C_INC, 12'h080, 12'h080, 3'd1, 1'b1, 1'b1, "call_wins");
    step(C_RET | C_CALL, 12'h700, 12'h034, 3'd0, 1'b1, 1'b1, "ret_wins");

    // 6. reset mid-operation with sp=3
    step(C_CALL, 12'h100, 12'h100, 3'd1, 1'b1, 1'b1, "m_call1");
    step(C_CALL, 12'h200, 12'h200, 3'd2, 1'b1, 1'b1, "m_call2");
    step(C_CALL, 12'h300, 12'h300, 3'd3, 1'b1, 1'b1, "m_call3");
    step(C_RST,  12'h000, 12'h000, 3'd0, 1'b0, 1'b0, "mid_reset");
    step(C_RET,  12'h000, 12'h000, 3'd0, 1'b0, 1'b1, "post_rst_unf");

    // return address wraps when calling from the top address
    step(C_RST,  12'h000, 12'h000, 3'd0, 1'b0, 1'b0, "reset3");
    step(C_LOAD, 12'hFFF, 12'hFFF, 3'd0, 1'b0, 1'b0, "load_fff");
    step(C_CALL, 12'h050, 12'h050, 3'd1, 1'b0, 1'b0, "call_top");
    step(C_RET,  12'h000, 12'h000, 3'd0, 1'b0, 1'b0, "ret_wrapped");

    {Rst, ret, call, loadPC, incPC} = 5'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    done = 1'b1;
  end

  initial begin
    wait (done);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised next-generation program counter for the Nibbler fetch path.
- Drives the ROM address bus.
- Beyond load and increment, adds subroutine call and return through an internal return-address stack, plus full/empty status and sticky overflow/underflow error flags.
- Sits between the control unit (issues loadPC/incPC/call/ret) and program ROM (consumes addr).

Parameters:
- ADDR_W, 12, program address width in bits.
- DEPTH, 4, return-stack entries (>=1).
- RESET_ADDR, 0, value loaded into addr on reset.
- INC_STEP, 1, amount added per increment.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- newaddr  input  ADDR_W  jump/call target.
- loadPC  input  1  load addr from newaddr.
- incPC  input  1  advance addr by INC_STEP.
- call  input  1  push return address, jump to newaddr.
- ret  input  1  pop return address into addr.
- addr  output  ADDR_W  current program address (registered).
- sp  output  clog2(DEPTH+1)  number of valid stack entries.
- stack_full  output  1  sp == DEPTH (combinational from sp).
- stack_empty  output  1  sp == 0 (combinational from sp).
- overflow  output  1  sticky: call attempted while full.
- underflow  output  1  sticky: ret attempted while empty.

Behaviour:
- One clock; reset is synchronous and active-high.
- Rst sampled on rising clk edge, highest priority. Results on reset:
  - addr = RESET_ADDR, sp = 0, overflow = 0, underflow = 0.
  - Hence stack_empty = 1 and stack_full = 0.
  - Stack RAM contents are not cleared; they are don't-care.
- Command priority when several are high in the same cycle: Rst > ret > call > loadPC > incPC > hold. Exactly one action per cycle.
- ret, stack not empty:
  - addr <= stack[sp-1]; sp <= sp-1.
- ret, stack empty:
  - addr and sp hold; underflow <= 1.
- call, stack not full:
  - stack[sp] <= (addr + INC_STEP) mod 2^ADDR_W; sp <= sp+1; addr <= newaddr.
- call, stack full:
  - Whole call is suppressed: no push, no jump, addr holds; overflow <= 1.
- loadPC: addr <= newaddr.
- incPC: addr <= (addr + INC_STEP) mod 2^ADDR_W.
  - Wraps, e.g. ADDR_W=12: 0xFFF -> 0x000.
- No command: all state holds.
- Latency:
  - Every addr change is visible one cycle after the sampling edge. No combinational path from inputs to addr.
  - A value popped by ret is the one pushed by the matching call; push/pop are LIFO.
- A return address computed at the top address wraps (call at 0xFFF pushes 0x000).
- overflow/underflow stay set until Rst; no other clear mechanism.
- Reset mid-sequence (e.g. with sp=3): next cycle sp=0, addr=RESET_ADDR, flags 0. A subsequent ret underflows.
- sp never exceeds DEPTH and never goes below 0 under any input sequence.

Test Plan (ADDR_W=12, DEPTH=4, RESET_ADDR=0, INC_STEP=1):
1. Reset then incPC held 5 cycles -> addr 0,1,2,3,4,5; stack_empty=1 throughout.
2. Reset vs. increment:
   - loadPC with newaddr=0xFFE, then incPC 3 cycles -> addr 0xFFE, 0xFFF, 0x000, 0x001.
   - Rst asserted together with incPC -> addr=0 next cycle.
3. Call/return pair:
   - At addr=0x010: call with newaddr=0x200 -> addr=0x200, sp=1.
   - incPC twice -> 0x202.
   - ret -> addr=0x011, sp=0.
4. Nested calls to full:
   - From addr=0x000, 4 calls targeting 0x100, 0x200, 0x300, 0x400 -> sp=4, stack_full=1.
   - 5th call to 0x500 -> addr stays 0x400, sp=4, overflow=1.
   - 4 rets -> addr 0x301, 0x201, 0x101, 0x001; overflow still 1.
5. Underflow and priority:
   - ret with sp=0 at addr=0x033 -> addr stays 0x033, underflow=1.
   - call+loadPC+incPC same cycle, newaddr=0x080 -> treated as call (sp=1, addr=0x080).
   - ret+call same cycle -> ret wins: addr=0x034, sp=0.
6. Reset mid-operation:
   - With sp=3, overflow=1, assert Rst one cycle -> sp=0, addr=0, overflow=0, underflow=0.
   - Following ret -> underflow=1, addr=0.
